// File: rtl/sub_pkg.sv
// Shared types and constants for the subtractor display path.
package sub_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StDone
    } state_e;

    localparam int unsigned BCD_DIGIT_W = 4;
    localparam logic [BCD_DIGIT_W-1:0] ADD3_THRESH = 4'd5;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more before the shift.
module bcd_digit_adj
    import sub_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] din,
    output logic [BCD_DIGIT_W-1:0] dout
);

    always_comb begin
        dout = din;
        if (din >= ADD3_THRESH) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/sub_bcd_converter.sv
// Signed difference to sign + packed BCD via sequential double dabble, valid/ready on both sides.
// Optional leading-zero blanking mask enabled by defining SUB_BCD_BLANK_EN.
module sub_bcd_converter
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH  = 6,
    parameter int unsigned DIGITS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_overflow,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_sign,
    output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
    output logic                          out_overflow,
    output logic [DIGITS-1:0]             out_blank
);

    localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mag_q, mag_d, mag_shift;
    logic [BCD_W-1:0] acc_q, acc_d, acc_adj, acc_shift;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             load, load_ovf;

    logic             res_sign_q, res_ovf_q;
    logic [BCD_W-1:0] res_bcd_q;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (acc_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .dout (acc_adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign {acc_shift, mag_shift} = {acc_adj, mag_q} << 1;

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        load     = 1'b0;
        load_ovf = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sign_d = in_data[WIDTH-1];
                    // Two's-complement negate in WIDTH bits: the most negative value maps to
                    // 2**(WIDTH-1), which is still representable unsigned.
                    mag_d  = in_data[WIDTH-1] ? (~in_data + 1'b1) : in_data;
                    acc_d  = '0;
                    cnt_d  = '0;
                    if (in_overflow) begin
                        state_d  = StDone;
                        load_ovf = 1'b1;
                    end else begin
                        state_d = StConvert;
                    end
                end
            end
            StConvert: begin
                acc_d = acc_shift;
                mag_d = mag_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                    load    = 1'b1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            mag_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
        end
    end

    // Result registers only change when entering DONE, so they hold across IDLE/CONVERT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_sign_q <= 1'b0;
            res_bcd_q  <= '0;
            res_ovf_q  <= 1'b0;
        end else if (load) begin
            res_sign_q <= sign_q;
            res_bcd_q  <= acc_shift;
            res_ovf_q  <= 1'b0;
        end else if (load_ovf) begin
            res_sign_q <= 1'b0;
            res_bcd_q  <= '0;
            res_ovf_q  <= 1'b1;
        end
    end

`ifdef SUB_BCD_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              lead;

    always_comb begin
        blank_d = blank_q;
        lead    = 1'b1;
        if (load_ovf) begin
            blank_d = '0;
            for (int i = 1; i < DIGITS; i++) begin
                blank_d[i] = 1'b1;
            end
        end else if (load) begin
            blank_d = '0;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && (acc_shift[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0)) begin
                    blank_d[i] = 1'b1;
                end else begin
                    lead = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign out_blank = blank_q;
`else
    assign out_blank = '0;
`endif

    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StDone);
    assign out_sign     = res_sign_q;
    assign out_bcd      = res_bcd_q;
    assign out_overflow = res_ovf_q;

endmodule

// File: tb/tb_sub_bcd_converter.sv
// Randomized self-checking bench for sub_bcd_converter against a decimal reference model.
module tb_sub_bcd_converter;

    localparam int unsigned WIDTH  = 6;
    localparam int unsigned DIGITS = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_overflow = 1'b0;
    logic                  out_ready = 1'b0;
    logic [WIDTH-1:0]      in_data = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic                  out_sign;
    logic [4*DIGITS-1:0]   out_bcd;
    logic                  out_overflow;
    logic [DIGITS-1:0]     out_blank;

    int n_vec = 0;
    int n_err = 0;

    sub_bcd_converter #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_bcd      (out_bcd),
        .out_overflow (out_overflow),
        .out_blank    (out_blank)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits of |value| by division, blanking from the digit list.
    task automatic ref_model(input logic [WIDTH-1:0] d, input logic ovf, output logic sign,
                             output logic [4*DIGITS-1:0] bcd, output logic [DIGITS-1:0] blank);
        int v, m, p;
        int dig[DIGITS];
        bit lead;
        v = int'($signed(d));
        sign = 1'b0;
        bcd = '0;
        blank = '0;
        if (ovf) begin
`ifdef SUB_BCD_BLANK_EN
            for (int i = 1; i < DIGITS; i++) blank[i] = 1'b1;
`endif
        end else begin
            sign = (v < 0);
            m = (v < 0) ? -v : v;
            p = 1;
            for (int i = 0; i < DIGITS; i++) begin
                dig[i] = (m / p) % 10;
                bcd[4*i +: 4] = 4'(dig[i]);
                p = p * 10;
            end
`ifdef SUB_BCD_BLANK_EN
            lead = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                if (lead && dig[i] == 0) blank[i] = 1'b1;
                else lead = 1'b0;
            end
`endif
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns in the same phase.
    task automatic run_sample(input logic [WIDTH-1:0] d, input logic ovf, input int hold,
                              input bit poke, input string tag);
        logic                esign;
        logic [4*DIGITS-1:0] ebcd;
        logic [DIGITS-1:0]   eblank;
        int                  lat;
        ref_model(d, ovf, esign, ebcd, eblank);
        in_valid    = 1'b1;
        in_data     = d;
        in_overflow = ovf;
        check_eq({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        in_data     = WIDTH'($urandom);
        in_overflow = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * WIDTH) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_eq({tag, ".latency"}, 32'(lat), ovf ? 32'd1 : 32'(WIDTH + 1));
        check_eq({tag, ".sign"}, 32'(out_sign), 32'(esign));
        check_eq({tag, ".bcd"}, 32'(out_bcd), 32'(ebcd));
        check_eq({tag, ".ovf"}, 32'(out_overflow), 32'(ovf));
        check_eq({tag, ".blank"}, 32'(out_blank), 32'(eblank));
        check_eq({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < hold; k++) begin
            if (poke) begin
                in_valid    = 1'b1;
                in_data     = WIDTH'($urandom);
                in_overflow = 1'($urandom);
            end
            @(posedge clk);
            #1;
            if (poke) begin
                check_eq({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                check_eq({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
                check_eq({tag, ".hold_bcd"}, 32'(out_bcd), 32'(ebcd));
                check_eq({tag, ".hold_sign"}, 32'(out_sign), 32'(esign));
                check_eq({tag, ".hold_ovf"}, 32'(out_overflow), 32'(ovf));
            end
        end
        in_valid = 1'b0;
        if (hold > 0) check_eq({tag, ".valid_held"}, 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
        check_eq({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
        check_eq({tag, ".bcd_retained"}, 32'(out_bcd), 32'(ebcd));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.in_ready", 32'(in_ready), 32'd1);
        check_eq("rst.out_valid", 32'(out_valid), 32'd0);
        check_eq("rst.sign", 32'(out_sign), 32'd0);
        check_eq("rst.bcd", 32'(out_bcd), 32'd0);
        check_eq("rst.ovf", 32'(out_overflow), 32'd0);
        check_eq("rst.blank", 32'(out_blank), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_sample(WIDTH'(25), 1'b0, 0, 1'b0, "pos25");
        run_sample(WIDTH'(-32), 1'b0, 0, 1'b0, "neg32");
        run_sample(WIDTH'(-1), 1'b0, 1, 1'b0, "neg1");
        run_sample(WIDTH'(0), 1'b0, 0, 1'b0, "zero");
        run_sample(WIDTH'(63), 1'b1, 0, 1'b0, "ovf3f");
        run_sample(WIDTH'(7), 1'b0, 0, 1'b0, "pos7");
        run_sample(WIDTH'(-19), 1'b0, 10, 1'b1, "hold");
        check_eq("post_hold.idle_valid", 32'(out_valid), 32'd0);

        // Abort a conversion with an asynchronous reset after a nonzero result is showing.
        run_sample(WIDTH'(-13), 1'b0, 0, 1'b0, "pre_rst");
        in_valid    = 1'b1;
        in_data     = WIDTH'(25);
        in_overflow = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst.in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst.out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst.sign", 32'(out_sign), 32'd0);
        check_eq("midrst.bcd", 32'(out_bcd), 32'd0);
        check_eq("midrst.ovf", 32'(out_overflow), 32'd0);
        check_eq("midrst.blank", 32'(out_blank), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_sample(WIDTH'(-27), 1'b0, 0, 1'b0, "after_rst");

        for (int v = -(2 ** (WIDTH - 1)); v < 2 ** (WIDTH - 1); v++) begin
            run_sample(WIDTH'(v), 1'b0, int'($urandom_range(0, 2)), 1'b0, "sweep");
        end

        for (int n = 0; n < 100; n++) begin
            run_sample(WIDTH'($urandom), 1'($urandom_range(0, 7) == 0),
                       int'($urandom_range(0, 3)), 1'($urandom), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
